// File: rtl/cpu_pkg.sv
// Shared definitions for the execute stage: micro-op codes, condition codes,
// flag bit positions and the condition evaluator.
package cpu_pkg;

  localparam logic [4:0] UOP_NOP = 5'd0;
  localparam logic [4:0] UOP_ADD = 5'd1;
  localparam logic [4:0] UOP_SUB = 5'd2;
  localparam logic [4:0] UOP_AND = 5'd3;
  localparam logic [4:0] UOP_EOR = 5'd4;
  localparam logic [4:0] UOP_CMP = 5'd5;
  localparam logic [4:0] UOP_LSL = 5'd6;
  localparam logic [4:0] UOP_LSR = 5'd7;
  localparam logic [4:0] UOP_MOV = 5'd8;
  localparam logic [4:0] UOP_STR = 5'd9;
  localparam logic [4:0] UOP_LDR = 5'd10;

  localparam logic [3:0] COND_EQ   = 4'b0000;
  localparam logic [3:0] COND_NE   = 4'b0001;
  localparam logic [3:0] COND_CS   = 4'b0010;
  localparam logic [3:0] COND_CC   = 4'b0011;
  localparam logic [3:0] COND_MI   = 4'b0100;
  localparam logic [3:0] COND_PL   = 4'b0101;
  localparam logic [3:0] COND_VS   = 4'b0110;
  localparam logic [3:0] COND_VC   = 4'b0111;
  localparam logic [3:0] COND_HI   = 4'b1000;
  localparam logic [3:0] COND_LS   = 4'b1001;
  localparam logic [3:0] COND_GE   = 4'b1010;
  localparam logic [3:0] COND_LT   = 4'b1011;
  localparam logic [3:0] COND_GT   = 4'b1100;
  localparam logic [3:0] COND_LE   = 4'b1101;
  localparam logic [3:0] COND_AL   = 4'b1110;
  localparam logic [3:0] COND_NONE = 4'b1111;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    n = nzcv[FLAG_N];
    z = nzcv[FLAG_Z];
    c = nzcv[FLAG_C];
    v = nzcv[FLAG_V];
    case (cond)
      COND_EQ: cond_holds = z;
      COND_NE: cond_holds = !z;
      COND_CS: cond_holds = c;
      COND_CC: cond_holds = !c;
      COND_MI: cond_holds = n;
      COND_PL: cond_holds = !n;
      COND_VS: cond_holds = v;
      COND_VC: cond_holds = !v;
      COND_HI: cond_holds = c && !z;
      COND_LS: cond_holds = !c || z;
      COND_GE: cond_holds = (n == v);
      COND_LT: cond_holds = (n != v);
      COND_GT: cond_holds = !z && (n == v);
      COND_LE: cond_holds = z || (n != v);
      COND_AL: cond_holds = 1'b1;
      default: cond_holds = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/execute_alu.sv
// Combinational ALU of the execute stage: arithmetic, logic, shifts, moves and
// the NZCV result of p0 - B.
module execute_alu
  import cpu_pkg::*;
(
  input  logic [4:0]  uop_i,
  input  logic [31:0] p0_i,
  input  logic [31:0] p1_i,
  input  logic [31:0] b_i,
  input  logic [4:0]  shamt_i,
  input  logic        use_imm_i,
  output logic [31:0] result_o,
  output logic [3:0]  nzcv_o
);

  // Subtract as p0 + ~B + 1 so the carry-out is the ARM "no borrow" flag.
  logic [32:0] diff;
  assign diff = {1'b0, p0_i} + {1'b0, ~b_i} + 33'd1;

  always_comb begin
    result_o = '0;
    case (uop_i)
      UOP_ADD: result_o = p0_i + b_i;
      UOP_SUB: result_o = diff[31:0];
      UOP_AND: result_o = p0_i & b_i;
      UOP_EOR: result_o = p0_i ^ b_i;
      UOP_CMP: result_o = diff[31:0];
      UOP_LSL: result_o = p1_i << shamt_i;
      UOP_LSR: result_o = p1_i >> shamt_i;
      UOP_MOV: result_o = use_imm_i ? b_i : p0_i;
      default: result_o = '0;
    endcase
  end

  always_comb begin
    nzcv_o         = '0;
    nzcv_o[FLAG_N] = diff[31];
    nzcv_o[FLAG_Z] = (diff[31:0] == 32'd0);
    nzcv_o[FLAG_C] = diff[32];
    nzcv_o[FLAG_V] = (p0_i[31] != b_i[31]) && (diff[31] != p0_i[31]);
  end

endmodule

// File: rtl/execute_unit.sv
// Single-cycle execute stage: register file, flags, data memory, branch
// resolution and the wrong-path flush window.
module execute_unit
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_DEPTH    = 64,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        num_to_rhs,
  input  logic [31:0] num,
  input  logic [3:0]  sel_p0,
  input  logic [3:0]  sel_p1,
  input  logic [3:0]  sel_in,
  input  logic [4:0]  uop,
  input  logic [3:0]  branch_cond,
  output logic        global_disable,
  output logic [31:0] delta_instruction
);

  localparam int unsigned AddrW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [31:0] rf_q [16];
  logic [3:0]  flags_q;
  logic [31:0] mem_q [MEM_DEPTH];
  logic [7:0]  flush_cnt_q, flush_cnt_d;
  logic        disable_q, disable_d;
  logic [31:0] delta_q, delta_d;

  logic [31:0]      p0, p1, b_op, addr, alu_result, wdata;
  logic [4:0]       shamt;
  logic [AddrW-1:0] mem_idx;
  logic [3:0]       alu_nzcv;
  logic             active, rf_we, flags_we, mem_we, taken;

  assign p0      = rf_q[sel_p0];
  assign p1      = rf_q[sel_p1];
  assign b_op    = num_to_rhs ? num : p1;
  assign shamt   = num_to_rhs ? num[4:0] : p0[4:0];
  assign addr    = p1 + (num_to_rhs ? num : 32'd0);
  assign mem_idx = AddrW'(addr % MEM_DEPTH);
  assign active  = !disable_q;

  execute_alu u_alu (
    .uop_i     (uop),
    .p0_i      (p0),
    .p1_i      (p1),
    .b_i       (b_op),
    .shamt_i   (shamt),
    .use_imm_i (num_to_rhs),
    .result_o  (alu_result),
    .nzcv_o    (alu_nzcv)
  );

  always_comb begin
    rf_we = 1'b0;
    case (uop)
      UOP_ADD, UOP_SUB, UOP_AND, UOP_EOR,
      UOP_LSL, UOP_LSR, UOP_MOV, UOP_LDR: rf_we = active;
      default: rf_we = 1'b0;
    endcase
  end

  assign flags_we = active && (uop == UOP_CMP);
  assign mem_we   = active && (uop == UOP_STR) && !rst;
  assign wdata    = (uop == UOP_LDR) ? mem_q[mem_idx] : alu_result;
  // Branch sees the flags from before this cycle's CMP.
  assign taken    = active && (branch_cond != COND_NONE) && cond_holds(branch_cond, flags_q);

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    disable_d   = disable_q;
    delta_d     = 32'd0;
    if (taken) begin
      disable_d   = 1'b1;
      flush_cnt_d = 8'(FLUSH_CYCLES - 1);
      delta_d     = num;
    end else if (disable_q) begin
      if (flush_cnt_q == 8'd0) begin
        disable_d = 1'b0;
      end else begin
        flush_cnt_d = flush_cnt_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        rf_q[i] <= '0;
      end
      flags_q     <= '0;
      flush_cnt_q <= '0;
      disable_q   <= 1'b0;
      delta_q     <= '0;
    end else begin
      if (rf_we) begin
        rf_q[sel_in] <= wdata;
      end
      if (flags_we) begin
        flags_q <= alu_nzcv;
      end
      flush_cnt_q <= flush_cnt_d;
      disable_q   <= disable_d;
      delta_q     <= delta_d;
    end
  end

  // Data memory is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_idx] <= p0;
    end
  end

  assign global_disable    = disable_q;
  assign delta_instruction = delta_q;

endmodule

// File: tb/tb_execute_unit.sv
// Bench for execute_unit: directed instruction stream, a behavioural model of
// the architectural state and a per-cycle comparison against it.
module tb_execute_unit;

  localparam int FLUSH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        num_to_rhs;
  logic [31:0] num;
  logic [3:0]  sel_p0, sel_p1, sel_in, branch_cond;
  logic [4:0]  uop;
  logic        global_disable;
  logic [31:0] delta_instruction;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Model state
  logic [31:0] m_rf [16];
  logic [31:0] m_mem [64];
  bit          m_n, m_z, m_c, m_v;
  int          m_flush_left;
  logic [31:0] m_delta;

  execute_unit #(.MEM_DEPTH(64), .FLUSH_CYCLES(FLUSH)) dut (
    .clk               (clk),
    .rst               (rst),
    .num_to_rhs        (num_to_rhs),
    .num               (num),
    .sel_p0            (sel_p0),
    .sel_p1            (sel_p1),
    .sel_in            (sel_in),
    .uop               (uop),
    .branch_cond       (branch_cond),
    .global_disable    (global_disable),
    .delta_instruction (delta_instruction)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic bit m_cond(input logic [3:0] c);
    case (c)
      4'd0:  return m_z;
      4'd1:  return !m_z;
      4'd2:  return m_c;
      4'd3:  return !m_c;
      4'd4:  return m_n;
      4'd5:  return !m_n;
      4'd6:  return m_v;
      4'd7:  return !m_v;
      4'd8:  return m_c && !m_z;
      4'd9:  return !m_c || m_z;
      4'd10: return m_n == m_v;
      4'd11: return m_n != m_v;
      4'd12: return !m_z && (m_n == m_v);
      4'd13: return m_z || (m_n != m_v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_edge();
    logic [31:0] p0, p1, b, r;
    longint      sd;
    int          s;
    bit          tk;
    if (rst) begin
      for (int i = 0; i < 16; i++) m_rf[i] = 0;
      {m_n, m_z, m_c, m_v} = 4'b0;
      m_flush_left = 0;
      m_delta = 0;
      return;
    end
    m_delta = 0;
    if (m_flush_left > 0) begin
      m_flush_left--;
      return;
    end
    p0 = m_rf[sel_p0];
    p1 = m_rf[sel_p1];
    b  = num_to_rhs ? num : p1;
    s  = num_to_rhs ? int'(num % 32) : int'(p0 % 32);
    tk = (branch_cond != 4'b1111) && m_cond(branch_cond);
    case (uop)
      5'd1: m_rf[sel_in] = p0 + b;
      5'd2: m_rf[sel_in] = p0 - b;
      5'd3: m_rf[sel_in] = p0 & b;
      5'd4: m_rf[sel_in] = p0 ^ b;
      5'd5: begin
        r   = p0 - b;
        sd  = longint'($signed(p0)) - longint'($signed(b));
        m_n = r[31];
        m_z = (r == 0);
        m_c = (p0 >= b);
        m_v = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
      end
      5'd6: m_rf[sel_in] = p1 << s;
      5'd7: m_rf[sel_in] = p1 >> s;
      5'd8: m_rf[sel_in] = num_to_rhs ? num : p0;
      5'd9: m_mem[(p1 + (num_to_rhs ? num : 0)) % 64] = p0;
      5'd10: m_rf[sel_in] = m_mem[(p1 + (num_to_rhs ? num : 0)) % 64];
      default: ;
    endcase
    if (tk) begin
      m_flush_left = FLUSH;
      m_delta = num;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("global_disable", 32'(global_disable), 32'(m_flush_left > 0));
      check("delta_instruction", delta_instruction, m_delta);
      check("flags", 32'(dut.flags_q), 32'({m_n, m_z, m_c, m_v}));
      for (int i = 0; i < 16; i++) begin
        check($sformatf("r%0d", i), dut.rf_q[i], m_rf[i]);
      end
    end
  end

  // Present one instruction, let the edge happen, then wait for the compare edge.
  task automatic step(input bit imm, input logic [31:0] n, input int p0, input int p1,
                      input int d, input int u, input logic [3:0] c);
    num_to_rhs  = imm;
    num         = n;
    sel_p0      = 4'(p0);
    sel_p1      = 4'(p1);
    sel_in      = 4'(d);
    uop         = 5'(u);
    branch_cond = c;
    @(posedge clk);
    model_edge();
    chk_en = 1'b1;
    @(negedge clk);
  endtask

  localparam logic [3:0] NB = 4'b1111;

  initial begin
    rst = 1'b1;
    step(0, 0, 0, 0, 0, 0, NB);
    check("reset_r1", dut.rf_q[1], 32'h0);
    check("reset_disable", 32'(global_disable), 32'h0);
    rst = 1'b0;

    step(1, 32'hCAFE, 0, 0, 1, 8, NB);
    step(1, 32'hDEAD, 0, 0, 2, 8, NB);
    step(0, 0, 2, 0, 3, 8, NB);
    check("mov_r3", dut.rf_q[3], 32'hDEAD);
    step(0, 0, 1, 2, 4, 1, NB);
    check("add_r4", dut.rf_q[4], 32'h1A9AB);
    step(0, 0, 0, 0, 0, 0, NB);
    step(0, 0, 0, 0, 0, 0, NB);
    step(0, 0, 2, 4, 2, 3, NB);
    check("and_r2", dut.rf_q[2], 32'h88A9);

    step(1, 1, 0, 0, 6, 8, NB);
    step(1, 1, 0, 0, 7, 8, NB);
    step(0, 0, 6, 7, 0, 5, NB);
    check("cmp_eq_flags", 32'(dut.flags_q), 32'b0110);
    step(1, 10, 0, 0, 0, 0, 4'b0001);
    check("ne_not_taken", 32'(global_disable), 32'h0);

    step(0, 0, 1, 7, 14, 1, NB);
    step(1, 28, 14, 6, 0, 9, NB);
    step(1, 28, 0, 6, 8, 10, NB);
    check("ldr_r8", dut.rf_q[8], 32'hCAFF);

    step(1, 10, 0, 0, 0, 0, 4'b1110);
    check("br_disable", 32'(global_disable), 32'h1);
    check("br_delta", delta_instruction, 32'd10);
    step(0, 0, 1, 3, 1, 4, NB);
    check("flush2_delta", delta_instruction, 32'd0);
    step(1, 8, 0, 8, 9, 6, NB);
    check("squash_r1", dut.rf_q[1], 32'hCAFE);
    check("squash_r9", dut.rf_q[9], 32'h0);
    step(1, 8, 0, 8, 9, 6, NB);
    check("lsl_r9", dut.rf_q[9], 32'h00CAFF00);

    step(1, 4, 0, 0, 11, 8, NB);
    step(0, 0, 11, 9, 12, 7, NB);
    check("lsr_r12", dut.rf_q[12], 32'h000CAFF0);
    step(1, 32'hCAFF1, 12, 0, 13, 2, NB);
    check("sub_wrap_r13", dut.rf_q[13], 32'hFFFFFFFF);

    step(1, 32'h80000000, 0, 0, 10, 8, NB);
    step(1, 1, 10, 0, 0, 5, NB);
    check("cmp_ovf_flags", 32'(dut.flags_q), 32'b0011);
    step(1, 32'hFFFFFFFC, 0, 0, 0, 0, 4'b1011);
    check("lt_delta", delta_instruction, 32'hFFFFFFFC);
    step(1, 7, 0, 0, 5, 8, 4'b1110);
    step(1, 99, 0, 0, 5, 8, 4'b1110);
    check("squashed_branch", 32'(global_disable), 32'h0);
    check("squashed_r5", dut.rf_q[5], 32'h0);
    step(1, 32'h15, 0, 0, 15, 8, 4'b1010);
    check("ge_not_taken", 32'(global_disable), 32'h0);
    check("r15_write", dut.rf_q[15], 32'h15);

    step(1, 100, 12, 6, 0, 9, NB);
    step(1, 37, 0, 0, 0, 10, NB);
    check("mem_wrap_r0", dut.rf_q[0], 32'h000CAFF0);

    step(1, 3, 0, 0, 0, 0, 4'b1110);
    rst = 1'b1;
    step(0, 0, 1, 2, 1, 1, NB);
    check("rst_disable", 32'(global_disable), 32'h0);
    check("rst_r1", dut.rf_q[1], 32'h0);
    check("rst_r15", dut.rf_q[15], 32'h0);
    rst = 1'b0;
    step(1, 32'h42, 0, 0, 3, 8, NB);
    check("post_rst_r3", dut.rf_q[3], 32'h42);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
